axi_llc_way_arbiter: RTL and testbench

AXI_LLC_WAY_ARBITER -- requirements
Module: axi_llc_way_arbiter

---
 rtl/axi_llc_pkg.sv | 28 ++
 rtl/axi_llc_way_arb_tree.sv | 76 +++++++
 rtl/fifo_v3.sv | 102 ++++++++++
 rtl/axi_llc_way_arbiter.sv | 145 ++++++++++++++
 tb/tb_axi_llc_way_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_llc_pkg.sv
// -----------------------------------------------------------------------------
// axi_llc_pkg
// Shared definitions for the LLC data-way access path: data macro latency,
// requesting unit indices, the route FIFO entry type and a default request
// payload carrying the write-enable field the way arbiter inspects.
// -----------------------------------------------------------------------------
package axi_llc_pkg;

   // Read latency of the data macro in cycles; sizes the outstanding-read route FIFO.
   localparam int unsigned DataMacroLatency = 2;

   // Requesting units, listed in fixed-priority order (lowest index wins).
   localparam int unsigned NumUnits   = 4;
   localparam int unsigned EvictUnit  = 0;
   localparam int unsigned RefillUnit = 1;
   localparam int unsigned WUnit      = 2;
   localparam int unsigned RUnit      = 3;

   // One route FIFO entry: the unit that owns an outstanding read.
   typedef logic [$clog2(NumUnits)-1:0] route_idx_t;

   // Default data way request payload. The arbiter only looks at `we`.
   typedef struct packed {
      logic        we;
      logic [31:0] data;
   } way_req_t;

endpackage

// File: rtl/axi_llc_way_arb_tree.sv
// -----------------------------------------------------------------------------
// axi_llc_way_arb_tree
// Combinational selection of one eligible requester.
//   AXI_LLC_WAY_ARB_RR_EN defined  : round-robin; the search starts at a
//                                    pointer that moves to (hs_idx_i+1) mod
//                                    NumReq after every handshake.
//   AXI_LLC_WAY_ARB_RR_EN undefined: fixed priority, lowest index wins; no
//                                    pointer register exists.
//
// Ports
//   clk_i     clock, rising edge
//   rst_i     asynchronous reset, active high (pointer back to 0)
//   req_i     per-unit eligible request
//   hs_i      a request handshake happened this cycle
//   hs_idx_i  index of the unit that completed that handshake
//   gnt_o     selected unit (0 when nothing is eligible)
// -----------------------------------------------------------------------------
module axi_llc_way_arb_tree #(
   parameter int unsigned NumReq = 4,
   parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NumReq-1:0] req_i,
   input  logic              hs_i,
   input  logic [IdxW-1:0]   hs_idx_i,
   output logic [IdxW-1:0]   gnt_o
);

   logic [IdxW-1:0] rr_ptr;
   logic [IdxW-1:0] cand;
   logic            found;

`ifdef AXI_LLC_WAY_ARB_RR_EN
   logic [IdxW-1:0] ptr_q, ptr_d;

   // The pointer follows the unit actually served, which may be a held grant
   // rather than this cycle's search result.
   always_comb begin
      ptr_d = ptr_q;
      if (hs_i) begin
         ptr_d = (hs_idx_i == IdxW'(NumReq - 1)) ? '0 : hs_idx_i + IdxW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign rr_ptr = ptr_q;
`else
   logic unused_rr;

   assign rr_ptr    = '0;
   assign unused_rr = ^{clk_i, rst_i, hs_i, hs_idx_i};
`endif

   // Scan starting at the pointer, wrapping; the first eligible unit wins.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         cand = IdxW'((32'(rr_ptr) + k) % NumReq);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            gnt_o = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_v3.sv
// -----------------------------------------------------------------------------
// fifo_v3
// Synchronous, non-fall-through FIFO of DEPTH entries. A push into a full
// FIFO and a pop from an empty FIFO are ignored; a push and pop in the same
// cycle on a non-full, non-empty FIFO keep the fill level unchanged.
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous reset, active low
//   flush_i     synchronous clear of all entries
//   testmode_i  unused, kept for drop-in compatibility
//   full_o      no free entry
//   empty_o     no stored entry
//   usage_o     fill level (low ADDR_DEPTH bits)
//   data_i      write data
//   push_i      write request
//   data_o      oldest entry (registered storage, not data_i)
//   pop_i       read/remove request
// -----------------------------------------------------------------------------
module fifo_v3 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  testmode_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [ADDR_DEPTH-1:0] usage_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i
);

   localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;
   localparam int unsigned CntW      = ADDR_DEPTH + 1;
   localparam logic [ADDR_DEPTH-1:0] LastPtr = ADDR_DEPTH'(FifoDepth - 1);

   logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [FifoDepth];
   logic                  push, pop;
   logic                  unused_testmode;

   assign unused_testmode = testmode_i;

   assign full_o  = (cnt_q == CntW'(FifoDepth));
   assign empty_o = (cnt_q == '0);
   assign usage_o = cnt_q[ADDR_DEPTH-1:0];
   assign data_o  = mem_q[rd_ptr_q];

   assign push = push_i & ~full_o;
   assign pop  = pop_i & ~empty_o;

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ADDR_DEPTH'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + ADDR_DEPTH'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!push && pop) begin
         cnt_d = cnt_q - CntW'(1);
      end
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // NOTE: storage is deliberately not reset; only the pointers and count are, and entries are never read while the count says empty.
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/axi_llc_way_arbiter.sv
// -----------------------------------------------------------------------------
// axi_llc_way_arbiter
// Arbitrates NumReq units (0 evict, 1 refill, 2 write, 3 read) onto a single
// LLC data way and routes read responses back to the unit that issued them.
// Grant is combinational (no added latency). A stalled grant is held until
// its handshake. Reads are only eligible while the route FIFO has room;
// writes are always eligible and leave no route entry.
// Build option: AXI_LLC_WAY_ARB_RR_EN selects round-robin instead of fixed
// priority.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active high
//   req_i            per-unit request payload
//   req_valid_i      per-unit request valid
//   req_ready_o      per-unit request accepted (only the granted bit)
//   way_inp_o        granted payload to the data way
//   way_inp_valid_o  data way request valid
//   way_inp_ready_i  data way ready
//   way_out_i        data way read response
//   way_out_valid_i  response valid
//   way_out_ready_o  response accepted
//   rsp_o            response payload, broadcast to all units
//   rsp_valid_o      response valid, one-hot to the owning unit
//   rsp_ready_i      per-unit response ready
// -----------------------------------------------------------------------------
module axi_llc_way_arbiter
   import axi_llc_pkg::*;
#(
   parameter int unsigned NumReq     = 4,
   parameter int unsigned RouteDepth = DataMacroLatency + 2,
   // Default payload types must carry `we` for the eligibility check.
   parameter type         way_inp_t  = way_req_t,
   parameter type         way_oup_t  = logic
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  way_inp_t [NumReq-1:0]   req_i,
   input  logic [NumReq-1:0]       req_valid_i,
   output logic [NumReq-1:0]       req_ready_o,
   output way_inp_t                way_inp_o,
   output logic                    way_inp_valid_o,
   input  logic                    way_inp_ready_i,
   input  way_oup_t                way_out_i,
   input  logic                    way_out_valid_i,
   output logic                    way_out_ready_o,
   output way_oup_t                rsp_o,
   output logic [NumReq-1:0]       rsp_valid_o,
   input  logic [NumReq-1:0]       rsp_ready_i
);

   localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned RouteW = (RouteDepth > 1) ? $clog2(RouteDepth) : 1;

   logic [NumReq-1:0] eligible;
   logic [IdxW-1:0]   tree_gnt;
   logic [IdxW-1:0]   gnt;
   logic              inp_hs;

   logic              hold_q, hold_d;
   logic [IdxW-1:0]   hold_idx_q, hold_idx_d;

   logic              route_full, route_empty;
   logic              route_push, route_pop;
   logic [IdxW-1:0]   route_head;
   logic [RouteW-1:0] unused_route_usage;

   // ---------------------------------------------------------------- request
   always_comb begin
      eligible = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         eligible[i] = req_valid_i[i] & (req_i[i].we | ~route_full);
      end
   end

   axi_llc_way_arb_tree #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) i_arb_tree (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    (eligible),
      .hs_i     (inp_hs),
      .hs_idx_i (gnt),
      .gnt_o    (tree_gnt)
   );

   // A request presented without a handshake keeps the grant on the next
   // cycle. The held unit stays eligible: the FIFO only fills on handshakes.
   assign gnt = hold_q ? hold_idx_q : tree_gnt;

   always_comb begin
      way_inp_o       = req_i[gnt];
      // Outputs are forced idle while reset is asserted, not just after it.
      way_inp_valid_o = eligible[gnt] & ~rst_i;
      inp_hs          = way_inp_valid_o & way_inp_ready_i;
      req_ready_o     = '0;
      req_ready_o[gnt] = inp_hs;
      route_push      = inp_hs & ~way_inp_o.we;
      hold_d          = way_inp_valid_o & ~way_inp_ready_i;
      hold_idx_d      = gnt;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_q     <= 1'b0;
         hold_idx_q <= '0;
      end else begin
         hold_q     <= hold_d;
         hold_idx_q <= hold_idx_d;
      end
   end

   // --------------------------------------------------------------- response
   fifo_v3 #(
      .DATA_WIDTH (IdxW),
      .DEPTH      (RouteDepth)
   ) i_route_fifo (
      .clk_i      (clk_i),
      .rst_ni     (~rst_i),
      .flush_i    (1'b0),
      .testmode_i (1'b0),
      .full_o     (route_full),
      .empty_o    (route_empty),
      .usage_o    (unused_route_usage),
      .data_i     (gnt),
      .push_i     (route_push),
      .data_o     (route_head),
      .pop_i      (route_pop)
   );

   // A response with no outstanding route is never acknowledged.
   always_comb begin
      rsp_o                   = way_out_i;
      rsp_valid_o             = '0;
      rsp_valid_o[route_head] = way_out_valid_i & ~route_empty;
      way_out_ready_o         = rsp_ready_i[route_head] & ~route_empty;
      route_pop               = way_out_valid_i & way_out_ready_o;
   end

   rsp_needs_route: assert property (
      @(posedge clk_i) disable iff (rst_i) way_out_valid_i |-> !route_empty
   );

endmodule

// File: tb/tb_axi_llc_way_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_llc_way_arbiter
// Directed bench for axi_llc_way_arbiter (NumReq=4, RouteDepth=4). Inputs
// change 1 ns after the rising edge; outputs are sampled a further 1 ns on.
// Arbitration expectations follow AXI_LLC_WAY_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_axi_llc_way_arbiter;

   typedef struct packed {
      logic       we;
      logic [7:0] tag;
   } tb_inp_t;
   typedef logic [7:0] tb_oup_t;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   tb_inp_t [3:0]  req_i;
   logic [3:0]     req_valid_i;
   logic [3:0]     req_ready_o;
   tb_inp_t        way_inp_o;
   logic           way_inp_valid_o;
   logic           way_inp_ready_i;
   tb_oup_t        way_out_i;
   logic           way_out_valid_i;
   logic           way_out_ready_o;
   tb_oup_t        rsp_o;
   logic [3:0]     rsp_valid_o;
   logic [3:0]     rsp_ready_i;

   int             n_checks = 0;
   int             n_fail   = 0;
   logic [3:0]     exp_gnt;

   always #5 clk_i = ~clk_i;

   axi_llc_way_arbiter #(
      .NumReq     (4),
      .RouteDepth (4),
      .way_inp_t  (tb_inp_t),
      .way_oup_t  (tb_oup_t)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .req_i           (req_i),
      .req_valid_i     (req_valid_i),
      .req_ready_o     (req_ready_o),
      .way_inp_o       (way_inp_o),
      .way_inp_valid_o (way_inp_valid_o),
      .way_inp_ready_i (way_inp_ready_i),
      .way_out_i       (way_out_i),
      .way_out_valid_i (way_out_valid_i),
      .way_out_ready_o (way_out_ready_o),
      .rsp_o           (rsp_o),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_ready_i     (rsp_ready_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   function automatic tb_inp_t mk(input logic we, input logic [7:0] tag);
      return '{we: we, tag: tag};
   endfunction

   initial begin
      req_i[0]        = mk(1'b1, 8'hA0);
      req_i[1]        = mk(1'b1, 8'hA1);
      req_i[2]        = mk(1'b1, 8'hA2);
      req_i[3]        = mk(1'b0, 8'hA3);
      req_valid_i     = 4'hF;
      way_inp_ready_i = 1'b1;
      way_out_i       = 8'h00;
      way_out_valid_i = 1'b0;
      rsp_ready_i     = 4'hF;

      // Reset: everything requesting, nothing may be accepted.
      #2;
      check("rst_req_ready", 32'(req_ready_o), 32'h0);
      check("rst_inp_valid", 32'(way_inp_valid_o), 32'h0);
      check("rst_out_ready", 32'(way_out_ready_o), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      cyc();
      cyc();
      rst_i       = 1'b0;
      req_valid_i = 4'h0;
      cyc();

      // Arbitration with all units requesting and the way always ready.
      req_valid_i = 4'hF;
`ifdef AXI_LLC_WAY_ARB_RR_EN
      // Seven handshakes 0,1,2,3,0,1,2 leave the pointer at 3.
      for (int i = 0; i < 7; i++) begin
         exp_gnt = 4'(1 << (i % 4));
         #1;
         check("rr_order", 32'(req_ready_o), 32'(exp_gnt));
         cyc();
      end
`else
      for (int i = 0; i < 3; i++) begin
         #1;
         check("fp_u0_wins", 32'(req_ready_o), 32'h1);
         check("fp_u0_payload", 32'(way_inp_o.tag), 32'hA0);
         cyc();
      end
      req_valid_i = 4'hE;
      #1;
      check("fp_u1", 32'(req_ready_o), 32'h2);
      cyc();
      req_valid_i = 4'hC;
      #1;
      check("fp_u2", 32'(req_ready_o), 32'h4);
      cyc();
      req_valid_i = 4'h8;
      #1;
      check("fp_u3", 32'(req_ready_o), 32'h8);
      check("fp_u3_payload", 32'(way_inp_o), 32'(mk(1'b0, 8'hA3)));
      cyc();
`endif
      req_valid_i = 4'h0;
      // Exactly one read (unit 3) was issued above.
      way_out_valid_i = 1'b1;
      way_out_i       = 8'h5A;
      #1;
      check("a_rsp_valid", 32'(rsp_valid_o), 32'h8);
      check("a_rsp_data", 32'(rsp_o), 32'h5A);
      check("a_out_ready", 32'(way_out_ready_o), 32'h1);
      cyc();
      way_out_valid_i = 1'b0;

      // Stalled read from unit 3 keeps the grant while unit 0 joins.
      way_inp_ready_i = 1'b0;
      req_valid_i     = 4'h8;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) req_valid_i = 4'h9;
         #1;
         check("hold_payload", 32'(way_inp_o.tag), 32'hA3);
         check("hold_valid", 32'(way_inp_valid_o), 32'h1);
         check("hold_no_ready", 32'(req_ready_o), 32'h0);
         cyc();
      end
      way_inp_ready_i = 1'b1;
      #1;
      check("hold_release", 32'(req_ready_o), 32'h8);
      cyc();
      #1;
      check("after_hold_u0", 32'(req_ready_o), 32'h1);
      cyc();
      req_valid_i     = 4'h0;
      way_out_valid_i = 1'b1;
      way_out_i       = 8'h66;
      #1;
      check("b_rsp_valid", 32'(rsp_valid_o), 32'h8);
      cyc();
      way_out_valid_i = 1'b0;

      // Route FIFO depth 4: four reads accepted, the fifth blocked, write passes.
      req_valid_i = 4'h8;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("fill_rd", 32'(req_ready_o), 32'h8);
         cyc();
      end
      #1;
      check("full_blocks_rd", 32'(req_ready_o), 32'h0);
      check("full_no_valid", 32'(way_inp_valid_o), 32'h0);
      req_valid_i = 4'hC;
      #1;
      check("full_wr_ok", 32'(req_ready_o), 32'h4);
      check("full_wr_payload", 32'(way_inp_o.tag), 32'hA2);
      cyc();
      req_valid_i     = 4'h0;
      way_out_valid_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         way_out_i = 8'(8'h10 + c);
         #1;
         check("drain_rsp_valid", 32'(rsp_valid_o), 32'h8);
         check("drain_rsp_data", 32'(rsp_o), 32'(8'h10 + c));
         cyc();
      end
      way_out_valid_i = 1'b0;
      #1;
      check("drained_idle", 32'(rsp_valid_o), 32'h0);

      // Reads 3,1,3 with unit 1 not ready for its response.
      req_i[1] = mk(1'b0, 8'hA1);
      req_valid_i = 4'h8;
      #1;
      check("ord_rd3a", 32'(req_ready_o), 32'h8);
      cyc();
      req_valid_i = 4'h2;
      #1;
      check("ord_rd1", 32'(req_ready_o), 32'h2);
      cyc();
      req_valid_i = 4'h8;
      #1;
      check("ord_rd3b", 32'(req_ready_o), 32'h8);
      cyc();
      req_valid_i     = 4'h0;
      way_out_valid_i = 1'b1;
      rsp_ready_i     = 4'hD;
      way_out_i       = 8'h31;
      #1;
      check("ord_rsp0", 32'(rsp_valid_o), 32'h8);
      check("ord_rsp0_ready", 32'(way_out_ready_o), 32'h1);
      cyc();
      way_out_i = 8'h32;
      #1;
      check("ord_rsp1", 32'(rsp_valid_o), 32'h2);
      check("ord_rsp1_stall", 32'(way_out_ready_o), 32'h0);
      cyc();
      #1;
      check("ord_rsp1_held", 32'(rsp_valid_o), 32'h2);
      rsp_ready_i = 4'hF;
      #1;
      check("ord_rsp1_go", 32'(way_out_ready_o), 32'h1);
      cyc();
      way_out_i = 8'h33;
      #1;
      check("ord_rsp2", 32'(rsp_valid_o), 32'h8);
      check("ord_rsp2_data", 32'(rsp_o), 32'h33);
      cyc();
      way_out_valid_i = 1'b0;

      // Reset with two reads outstanding discards their routes.
      req_valid_i = 4'h8;
      cyc();
      cyc();
      req_valid_i = 4'hF;
      rst_i       = 1'b1;
      #1;
      check("mid_rst_req_ready", 32'(req_ready_o), 32'h0);
      check("mid_rst_inp_valid", 32'(way_inp_valid_o), 32'h0);
      check("mid_rst_out_ready", 32'(way_out_ready_o), 32'h0);
      check("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
      cyc();
      rst_i       = 1'b0;
      req_valid_i = 4'h0;
      cyc();
      req_valid_i = 4'h2;
      #1;
      check("post_rst_rd1", 32'(req_ready_o), 32'h2);
      cyc();
      req_valid_i     = 4'h0;
      way_out_valid_i = 1'b1;
      way_out_i       = 8'h77;
      #1;
      check("post_rst_route", 32'(rsp_valid_o), 32'h2);
      cyc();
      way_out_valid_i = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
